level_meter_scheduler: RTL and testbench

- Shares one peak-to-peak (max minus min over a section) datapath between CHANNELS audio sample streams, for example stereo L/R.
- Keeps max, min and count for each channel in register arrays.
- Grants input streams round-robin and tags each section result with its channel number.
- Sits between the per-channel sample sources and the level-meter display / bar-scaling logic.

---
 rtl/level_meter_pkg.sv | 15 +
 rtl/level_meter_scheduler_rr_arbiter.sv | 34 +++
 rtl/level_meter_scheduler.sv | 117 +++++++++++
 tb/tb_level_meter_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/level_meter_pkg.sv
// Shared types for the level-meter scheduler: FSM state encoding and index-width helper.
package level_meter_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  // A channel index always needs at least one bit, even for a single stream.
  function automatic int chanIdxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/level_meter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the last grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int   cand;
  logic found;

  // Walk last+1 .. last+N so the previously granted channel has the lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (enable && !found && req[IW'(cand)]) begin
        found             = 1'b1;
        grant[IW'(cand)]  = 1'b1;
        grant_idx         = IW'(cand);
      end
    end
    any = found;
  end

endmodule

// File: rtl/level_meter_scheduler.sv
// Time-shares one peak-to-peak (max minus min) datapath between several audio
// sample streams, emitting one tagged result per completed section.
module level_meter_scheduler
  import level_meter_pkg::*;
#(
  parameter  int CHANNELS     = 2,
  parameter  int SAMPLE_COUNT = 735,
  parameter  int WIDTH        = 16,
  localparam int CW           = chanIdxWidth(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       i_ready,
  input  logic [CHANNELS*WIDTH-1:0] i_value,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [CW-1:0]             o_channel,
  output logic [WIDTH-1:0]          o_value
);

  localparam int CNTW = $clog2(SAMPLE_COUNT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     last_grant_q;
  logic [CW-1:0]     chan_q;
  logic [WIDTH-1:0]  sample_q;
  logic [WIDTH-1:0]  max_q   [CHANNELS];
  logic [WIDTH-1:0]  min_q   [CHANNELS];
  logic [CNTW-1:0]   count_q [CHANNELS];
  logic              o_valid_q;
  logic [CW-1:0]     o_channel_q;
  logic [WIDTH-1:0]  o_value_q;

  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic                grant_any;
  logic                section_done;

  // Arbitration only happens in ARB, so i_ready never depends on o_ready.
  rr_arbiter #(
    .N  (CHANNELS),
    .IW (CW)
  ) u_arb (
    .req       (i_valid),
    .last      (last_grant_q),
    .enable    (state_q == ARB),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign i_ready      = grant;
  assign section_done = (count_q[chan_q] == CNTW'(SAMPLE_COUNT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (grant_any) state_d = UPDATE;
      UPDATE:  state_d = section_done ? EMIT : ARB;
      EMIT:    if (o_ready) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // The sample that closes a section seeds the next one, hence max/min <= sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB;
      last_grant_q <= CW'(CHANNELS - 1);
      chan_q       <= '0;
      sample_q     <= '0;
      o_valid_q    <= 1'b0;
      o_channel_q  <= '0;
      o_value_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        max_q[c]   <= '0;
        min_q[c]   <= '1;
        count_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ARB: begin
          if (grant_any) begin
            sample_q     <= i_value[grant_idx*WIDTH +: WIDTH];
            chan_q       <= grant_idx;
            last_grant_q <= grant_idx;
          end
        end
        UPDATE: begin
          if (section_done) begin
            o_value_q       <= max_q[chan_q] - min_q[chan_q];
            o_channel_q     <= chan_q;
            o_valid_q       <= 1'b1;
            max_q[chan_q]   <= sample_q;
            min_q[chan_q]   <= sample_q;
            count_q[chan_q] <= '0;
          end else begin
            if (sample_q > max_q[chan_q]) max_q[chan_q] <= sample_q;
            if (sample_q < min_q[chan_q]) min_q[chan_q] <= sample_q;
            count_q[chan_q] <= count_q[chan_q] + 1'b1;
          end
        end
        EMIT: begin
          if (o_ready) o_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_valid   = o_valid_q;
  assign o_channel = o_channel_q;
  assign o_value   = o_value_q;

endmodule

// File: tb/tb_level_meter_scheduler.sv
// Directed self-checking bench for level_meter_scheduler with two channels and
// four-sample sections; expected results are worked out by hand.
module tb_level_meter_scheduler;

  localparam int CH = 2;
  localparam int SC = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] i_valid;
  logic [CH-1:0] i_ready;
  logic [CH*W-1:0] i_value;
  logic          o_valid;
  logic          o_ready;
  logic [0:0]    o_channel;
  logic [W-1:0]  o_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  level_meter_scheduler #(
    .CHANNELS     (CH),
    .SAMPLE_COUNT (SC),
    .WIDTH        (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_value   (i_value),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_channel (o_channel),
    .o_value   (o_value)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample on a single channel, wait for its grant, then withdraw it.
  task automatic applyStimulus(input int ch, input logic [W-1:0] val);
    int waitCycles;
    waitCycles = 0;
    i_valid = '0;
    i_valid[ch] = 1'b1;
    i_value[ch*W +: W] = val;
    #1;
    while (!i_ready[ch] && waitCycles < 20) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!i_ready[ch]) checkOutput("grantTimeout", 32'(i_ready), 32'(1 << ch));
    else @(posedge clk);
    @(negedge clk);
    i_valid = '0;
  endtask

  task automatic collectResult(input string tag, input int expCh, input int expVal);
    int waitCycles;
    waitCycles = 0;
    while (!o_valid && waitCycles < 20) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    checkOutput({tag, "_valid"}, 32'(o_valid), 1);
    checkOutput({tag, "_chan"}, 32'(o_channel), expCh);
    checkOutput({tag, "_value"}, 32'(o_value), expVal);
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    #1;
    checkOutput({tag, "_drop"}, 32'(o_valid), 0);
  endtask

  task automatic doReset();
    reset   = 1'b0;
    i_valid = '0;
    o_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ovalid", 32'(o_valid), 0);
    checkOutput("rst_iready", 32'(i_ready), 0);
    checkOutput("rst_ovalue", 32'(o_value), 0);
    checkOutput("rst_ochan", 32'(o_channel), 0);
    reset = 1'b1;
  endtask

  initial begin
    int ch1Cnt;
    logic [31:0] expGrant;

    reset   = 1'b0;
    i_valid = '0;
    i_value = '0;
    o_ready = 1'b0;
    ch1Cnt  = 0;

    doReset();

    i_valid = 2'b01;
    i_value[W-1:0] = 16'd10;
    #1;
    checkOutput("firstGrant", 32'(i_ready), 1);

    // First section: 10,20,5,15 then 7 closes it -> 20-5
    applyStimulus(0, 16'd10);
    applyStimulus(0, 16'd20);
    applyStimulus(0, 16'd5);
    applyStimulus(0, 16'd15);
    applyStimulus(0, 16'd7);
    collectResult("sec1", 0, 15);

    // Seeded section: 7 + 9,3,9,9 then 1 closes it -> 9-3
    applyStimulus(0, 16'd9);
    applyStimulus(0, 16'd3);
    applyStimulus(0, 16'd9);
    applyStimulus(0, 16'd9);
    applyStimulus(0, 16'd1);
    collectResult("sec2", 0, 6);

    doReset();

    // Both channels request continuously: ch0 constant 100, ch1 alternates 0/65535
    for (int k = 0; k < 8; k++) begin
      i_valid = 2'b11;
      i_value[W-1:0]   = 16'd100;
      i_value[2*W-1:W] = (ch1Cnt % 2 == 1) ? 16'hFFFF : 16'h0000;
      #1;
      expGrant = (k % 2 == 0) ? 32'd1 : 32'd2;
      checkOutput($sformatf("rrGrant%0d", k), 32'(i_ready), expGrant);
      if (k % 2 == 1) ch1Cnt++;
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput($sformatf("rrUpdate%0d", k), 32'(i_ready), 0);
      @(negedge clk);
    end

    #1;
    checkOutput("ch0CloseGrant", 32'(i_ready), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("latencyNoValid", 32'(o_valid), 0);

    repeat (10) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", 32'(o_valid), 1);
      checkOutput("bp_value", 32'(o_value), 0);
      checkOutput("bp_chan", 32'(o_channel), 0);
      checkOutput("bp_iready", 32'(i_ready), 0);
    end

    @(negedge clk);
    o_ready = 1'b1;
    i_value[2*W-1:W] = 16'h0000;
    #1;
    checkOutput("bp_holdLast", 32'(o_valid), 1);
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    #1;
    checkOutput("bp_released", 32'(o_valid), 0);
    checkOutput("ch1CloseGrant", 32'(i_ready), 2);
    @(posedge clk);
    @(negedge clk);
    i_valid = '0;
    #1;
    checkOutput("ch1Update", 32'(i_ready), 0);
    @(negedge clk);
    #1;
    checkOutput("ch1_valid", 32'(o_valid), 1);
    checkOutput("ch1_chan", 32'(o_channel), 1);
    checkOutput("ch1_value", 32'(o_value), 65535);

    // Reset while the ch1 result is still pending
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midRst_valid", 32'(o_valid), 0);
    checkOutput("midRst_value", 32'(o_value), 0);
    checkOutput("midRst_chan", 32'(o_channel), 0);
    reset = 1'b1;
    @(negedge clk);

    // Fresh first-length section on ch1: 50..80 then 90 closes it -> 80-50
    applyStimulus(1, 16'd50);
    applyStimulus(1, 16'd60);
    applyStimulus(1, 16'd70);
    applyStimulus(1, 16'd80);
    applyStimulus(1, 16'd90);
    collectResult("fresh", 1, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
